// File: rtl/argmax32_stream.sv
// rtl/argmax32_stream.sv - streaming unsigned 32-bit max/argmax over a valid/ready frame (option: ARGMAX32_TIE_LAST_EN)
module argmax32_stream #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  // Count value meaning "2^IDX_W elements already seen"; one is the first element.
  localparam logic [IDX_W:0] CNT_FULL = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      max_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   cnt_q;
  logic             ovf_q;
  logic             in_ready_q;

  logic accept;
  logic upd;
  logic cnt_full;

  assign accept   = in_valid & in_ready_q;
  assign cnt_full = (cnt_q == CNT_FULL);

`ifdef ARGMAX32_TIE_LAST_EN
  assign upd = (in_data >= max_q);
`else
  assign upd = (in_data > max_q);
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == S_DONE);
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_ovf   = ovf_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: frame starts in IDLE, ends on an accepted in_last, result drains on out handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = in_last ? S_DONE : S_ACCUM;
      S_ACCUM: if (accept && in_last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered ready: low in reset, then tracks whether the next state can take a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready_q <= 1'b0;
    else     in_ready_q <= (state_d != S_DONE);
  end

  // Running max/index/count; accept can only happen in IDLE or ACCUM since ready is low in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      if (state_q == S_IDLE) begin
        max_q <= in_data;
        idx_q <= '0;
        cnt_q <= CNT_ONE;
        ovf_q <= 1'b0;
      end else begin
        if (upd) begin
          max_q <= in_data;
          idx_q <= cnt_full ? {IDX_W{1'b1}} : cnt_q[IDX_W-1:0];
        end
        if (cnt_full) ovf_q <= 1'b1;
        else          cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_argmax32_stream.sv
// tb/tb_argmax32_stream.sv - directed self-checking bench for argmax32_stream
module tb_argmax32_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_max;
  logic [7:0]  out_idx;

  logic        in_ready2, out_valid2, out_ovf2;
  logic [31:0] out_max2;
  logic [1:0]  out_idx2;

  int tests = 0;
  int fails = 0;

`ifdef ARGMAX32_TIE_LAST_EN
  localparam logic [7:0] TIE_IDX = 8'd3;
`else
  localparam logic [7:0] TIE_IDX = 8'd1;
`endif

  always #5 clk = ~clk;

  argmax32_stream #(.IDX_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx), .out_ovf(out_ovf)
  );

  // Narrow-index instance sharing the same stream to exercise overflow.
  argmax32_stream #(.IDX_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_max(out_max2), .out_idx(out_idx2), .out_ovf(out_ovf2)
  );

  task automatic send(input logic [31:0] d, input logic last);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [31:0] emax,
                              input logic [7:0] eidx, input logic eovf);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_valid: got %b required 1", name, out_valid); end
    tests++;
    if (out_max !== emax) begin fails++; $display("FAIL %s_max: got %h required %h", name, out_max, emax); end
    tests++;
    if (out_idx !== eidx) begin fails++; $display("FAIL %s_idx: got %0d required %0d", name, out_idx, eidx); end
    tests++;
    if (out_ovf !== eovf) begin fails++; $display("FAIL %s_ovf: got %b required %b", name, out_ovf, eovf); end
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL %s_ready_low: got %b required 0", name, in_ready); end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_drain: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, out_valid, out_max, out_idx, out_ovf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b vld=%b max=%h idx=%0d ovf=%b required all 0",
               in_ready, out_valid, out_max, out_idx, out_ovf);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_hold: got %b required 0", in_ready); end
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_rise: got %b required 1", in_ready); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send(32'd5, 1'b0);
    send(32'd9, 1'b0);
    send(32'd3, 1'b0);
    send(32'd9, 1'b0);
    send(32'd1, 1'b1);
    check_result("basic", 32'd9, TIE_IDX, 1'b0);
    drain("basic");
  endtask

  task automatic test_unsigned;
    send(32'hFFFF_FFFF, 1'b1);
    check_result("single", 32'hFFFF_FFFF, 8'd0, 1'b0);
    drain("single");
    send(32'h8000_0000, 1'b0);
    send(32'h7FFF_FFFF, 1'b1);
    check_result("unsigned", 32'h8000_0000, 8'd0, 1'b0);
    drain("unsigned");
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== 32'd3 || out_idx !== 8'd2) begin
        fails++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b max=%0d idx=%0d required 1/0/3/2",
                 i, out_valid, in_ready, out_max, out_idx);
      end
    end
    drain("bp");
  endtask

  task automatic test_gaps;
    int n;
    for (int i = 0; i < 16; i++) begin
      n = $urandom_range(0, 1);
      for (int g = 0; g < n; g++) begin @(posedge clk); #1; end
      send(32'(i), (i == 15));
    end
    check_result("gaps", 32'd15, 8'd15, 1'b0);
    drain("gaps");
  endtask

  task automatic test_overflow;
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b0);
    send(32'd40, 1'b0);
    send(32'd50, 1'b0);
    send(32'd100, 1'b1);
    check_result("wide", 32'd100, 8'd5, 1'b0);
    tests++;
    if (out_valid2 !== 1'b1 || out_max2 !== 32'd100 || out_idx2 !== 2'd3 || out_ovf2 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_narrow: vld=%b max=%0d idx=%0d ovf=%b required 1/100/3/1",
               out_valid2, out_max2, out_idx2, out_ovf2);
    end
    drain("ovf");
  endtask

  task automatic test_reset_midframe;
    send(32'd50, 1'b0);
    send(32'd60, 1'b0);
    send(32'd70, 1'b0);
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, out_max, out_idx, out_ovf} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: rdy=%b vld=%b max=%h idx=%0d ovf=%b required all 0",
               in_ready, out_valid, out_max, out_idx, out_ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(32'd7, 1'b0);
    send(32'd4, 1'b1);
    check_result("after_reset", 32'd7, 8'd0, 1'b0);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unsigned();
    test_backpressure();
    test_gaps();
    test_overflow();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
